// File: rtl/bus_arb_n.sv
// N-channel Wishbone-classic arbiter: one downstream slave shared by N masters,
// fixed or round-robin priority, optional watchdog that errors out a hung slave.

module bus_arb_n_lane #(
   parameter int DW = 32
) (
   input  logic          own,
   input  logic          in_busy,
   input  logic          in_err,
   input  logic          x_ack,
   input  logic [DW-1:0] x_rdt,
   output logic          ack,
   output logic          err,
   output logic [DW-1:0] rdt
);
   assign ack = own & in_busy & x_ack;
   assign err = own & in_err;
   assign rdt = (own & in_busy) ? x_rdt : '0;
endmodule

module bus_arb_n #(
   parameter int N           = 4,
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int ROUND_ROBIN = 0,
   parameter int TIMEOUT     = 0,
   localparam int SW         = DW / 8,
   localparam int GW         = $clog2(N)
) (
   input  logic            wb_clk,
   input  logic            wb_rst,
   input  logic [N-1:0]    m_cyc,
   input  logic [N-1:0]    m_we,
   input  logic [N*AW-1:0] m_adr,
   input  logic [N*DW-1:0] m_dat,
   input  logic [N*SW-1:0] m_sel,
   output logic [N-1:0]    m_ack,
   output logic [N-1:0]    m_err,
   output logic [N*DW-1:0] m_rdt,
   output logic            x_cyc,
   output logic            x_we,
   output logic [AW-1:0]   x_adr,
   output logic [DW-1:0]   x_dat,
   output logic [SW-1:0]   x_sel,
   input  logic            x_ack,
   input  logic [DW-1:0]   x_rdt,
   output logic [N-1:0]    grant,
   output logic            busy
);
   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

   state_t        state, state_nx;
   logic [GW-1:0] g, g_nx, p, p_nx, win;
   logic [N-1:0]  grant_nx;
   logic [GW:0]   c;
   logic          found, own_cyc, wd_fire, err_st, st_busy;

   // Winner search: candidates visited in priority order, first requester wins.
   // In round-robin mode the order starts at p and wraps at N.
   always_comb begin
      win   = '0;
      found = 1'b0;
      c     = '0;
      for (int k = 0; k < N; k++) begin
         c = (GW+1)'(k);
         if (ROUND_ROBIN != 0) begin
            c = {1'b0, p} + (GW+1)'(k);
            if (c >= (GW+1)'(N)) c = c - (GW+1)'(N);
         end
         if (!found && m_cyc[c[GW-1:0]]) begin
            found = 1'b1;
            win   = c[GW-1:0];
         end
      end
   end

   always_comb begin
      own_cyc = 1'b0;
      x_we    = 1'b0;
      x_adr   = '0;
      x_dat   = '0;
      x_sel   = '0;
      for (int i = 0; i < N; i++) begin
         if (g == GW'(i)) begin
            own_cyc = m_cyc[i];
            x_we    = m_we[i];
            x_adr   = m_adr[i*AW +: AW];
            x_dat   = m_dat[i*DW +: DW];
            x_sel   = m_sel[i*SW +: SW];
         end
      end
   end

   assign st_busy = (state == BUSY);
   assign x_cyc   = st_busy & own_cyc;
   assign busy    = (state != IDLE);

   generate
      if (TIMEOUT > 0) begin : g_wd
         localparam int WW = $clog2(TIMEOUT + 1);
         logic [WW-1:0] wd;
         // Holding wd at zero outside BUSY is what clears it on BUSY entry.
         always_ff @(posedge wb_clk) begin
            if (wb_rst || !st_busy) wd <= '0;
            else if (!x_ack)        wd <= wd + 1'b1;
         end
         assign wd_fire = st_busy && !x_ack && (wd == WW'(TIMEOUT - 1));
         assign err_st  = (state == ERR);
      end else begin : g_nowd
         assign wd_fire = 1'b0;
         assign err_st  = 1'b0;
      end
   endgenerate

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state <= IDLE;
         g     <= '0;
         p     <= '0;
         grant <= '0;
      end else begin
         state <= state_nx;
         g     <= g_nx;
         p     <= p_nx;
         grant <= grant_nx;
      end
   end

   always_comb begin
      state_nx = state;
      g_nx     = g;
      p_nx     = p;
      grant_nx = grant;
      case (state)
         IDLE: if (found) begin
            state_nx      = BUSY;
            g_nx          = win;
            grant_nx      = '0;
            grant_nx[win] = 1'b1;
            if (ROUND_ROBIN != 0) p_nx = (win == GW'(N - 1)) ? '0 : win + 1'b1;
         end
         // An ack beats both an abandon and a coinciding timeout.
         BUSY: if (x_ack || !own_cyc) begin
            state_nx = IDLE;
            grant_nx = '0;
         end else if (wd_fire) begin
            state_nx = ERR;
         end
         ERR: begin
            state_nx = IDLE;
            grant_nx = '0;
         end
         default: begin
            state_nx = IDLE;
            grant_nx = '0;
         end
      endcase
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      bus_arb_n_lane #(.DW(DW)) u_lane (
         .own    (grant[i]),
         .in_busy(st_busy),
         .in_err (err_st),
         .x_ack  (x_ack),
         .x_rdt  (x_rdt),
         .ack    (m_ack[i]),
         .err    (m_err[i]),
         .rdt    (m_rdt[i*DW +: DW])
      );
   end
endmodule
